// File: rtl/data_mem_responder.sv
// data_mem_responder: 2^ADDR_W x DATA_W synchronous data memory for the CPU data port,
// with fixed RD_LAT read pipeline, idle-time preload port and saturating access counters.
module data_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic              i_d_we,
  input  logic [DATA_W-1:0] i_d_dataout,
  output logic [DATA_W-1:0] o_d_datain,
  output logic              o_rd_valid,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic [15:0]       o_rd_count,
  output logic [15:0]       o_wr_count
);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("data_mem_responder: RD_LAT must be in 1..4");
  end
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              w_rd, w_wr, w_ld;
  logic              w_vld [RD_LAT];
  logic [DATA_W-1:0] w_dat [RD_LAT];
  assign w_rd = i_enable & ~i_d_we;
  assign w_wr = i_enable & i_d_we;
  assign w_ld = i_ld_valid & o_ld_ready & ~i_enable;
  assign w_vld[0] = w_rd;
  assign w_dat[0] = r_mem[i_d_addr];
  // Array is never reset so contents survive a reset pulse.
  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[i_d_addr] <= i_d_dataout;
    else if (w_ld) r_mem[i_ld_addr] <= i_ld_data;
  end
  for (genvar k = 1; k < RD_LAT; k++) begin : g_stage
    logic              r_vld;
    logic [DATA_W-1:0] r_dat;
    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else begin
        r_vld <= w_vld[k-1];
        r_dat <= w_dat[k-1];
      end
    end
    assign w_vld[k] = r_vld;
    assign w_dat[k] = r_dat;
  end
  // Output register is the final pipeline stage; it only reloads on completion.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_d_datain <= '0;
      o_rd_valid <= 1'b0;
      o_ld_ready <= 1'b0;
      o_rd_count <= '0;
      o_wr_count <= '0;
    end else begin
      o_rd_valid <= w_vld[RD_LAT-1];
      o_ld_ready <= ~i_enable;
      if (w_vld[RD_LAT-1]) o_d_datain <= w_dat[RD_LAT-1];
      if (w_vld[RD_LAT-1] && o_rd_count != 16'hFFFF) o_rd_count <= o_rd_count + 16'd1;
      if (w_wr && o_wr_count != 16'hFFFF) o_wr_count <= o_wr_count + 16'd1;
    end
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline CPU data port: a 256×16 synchronous data memory that answers the CPU's `d_addr`/`d_we`/`d_dataout` requests and returns read data on `d_datain` after a fixed, parameterised latency. It replaces the hand-timed `d_datain` stimulus in CPU-level benches, so programs with LOAD/STORE run end to end. It also has a side-band preload port for filling memory while the CPU is idle, and read/write access counters for checking.

## Interface
- `ADDR_W`, 8: address width; depth is 2^ADDR_W words.
- `DATA_W`, 16: data word width.
- `RD_LAT`, 2: read latency in clocks, legal range 1..4. Any other value is an elaboration error.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Clears the pipeline, counters and outputs; memory array contents are untouched.
- `enable` in 1: CPU running. Accesses are accepted only when high.
- `d_addr` in ADDR_W: CPU data address.
- `d_we` in 1: 1 = write, 0 = read, sampled when `enable` = 1.
- `d_dataout` in DATA_W: CPU write data.
- `d_datain` out DATA_W: read data returned to the CPU.
- `rd_valid` out 1: one-cycle pulse, aligned with each new `d_datain` value.
- `ld_valid` in 1: preload request.
- `ld_addr` in ADDR_W: preload address.
- `ld_data` in DATA_W: preload data.
- `ld_ready` out 1: preload accepted this cycle when high.
- `rd_count` out 16: completed reads, saturating.
- `wr_count` out 16: CPU writes, saturating. Preload writes are not counted.

## Operation
- **Access sampling.** Every rising edge with `enable` = 1 is one CPU access; a single port serves one access per cycle.
- **Write** (`d_we` = 1): `mem[d_addr]` <= `d_dataout` at that edge. `wr_count` increments.
- **Read** (`d_we` = 0):
  - `mem[d_addr]` is read at the sampling edge into stage 0 of a RD_LAT-deep valid/data shift pipeline.
  - When the final stage completes, `d_datain` is loaded and `rd_valid` pulses; `rd_count` increments on that same edge.
- **Holding.** `d_datain` holds its last value between reads. It changes only on read completion.
- **Read-after-write.** A read sampled on any edge after a write to the same address returns the new data. No bypass logic is needed because a write and a read cannot occur in the same cycle.
- **Stall.** `enable` = 0 samples no new access. In-flight reads keep advancing and complete normally.
- **Preload.**
  - `ld_ready` is a register loaded with ~`enable` on every edge, so it lags `enable` by one cycle.
  - A preload write (`mem[ld_addr]` <= `ld_data`) happens only when `ld_valid` && `ld_ready` && !`enable`.
  - Preload never touches `d_datain`, `rd_valid` or the counters.
- **Counters.** Both counters stop at 16'hFFFF and do not wrap.
- **Address wrap.** Addresses are used modulo 2^ADDR_W; no out-of-range case exists.

## Timing
- **Reset values:** `d_datain` = 0, `rd_valid` = 0, `ld_ready` = 0, `rd_count` = 0, `wr_count` = 0, all pipeline valid bits = 0.
- **Read latency:** read sampled at edge E → `d_datain`/`rd_valid` update at edge E + RD_LAT − 1. RD_LAT = 1 is a plain synchronous RAM.
- **Throughput:** back-to-back reads give back-to-back `rd_valid` pulses, one per cycle, in order.
- **Write:** visible to a read sampled at edge E+1 for a write at edge E.
- **Reset asserted mid-operation:** in-flight reads are dropped with no `d_datain` update. Counters and outputs clear immediately (asynchronously). Memory keeps its contents.
- **`enable` falling:** `ld_ready` rises one edge later. **`enable` rising:** `ld_ready` falls one edge later, but preload is already blocked that cycle by the !`enable` term.

## Test plan
- **Preload then read.** Reset, `enable` = 0, preload mem[0] = 16'h00AB and mem[1] = 16'h3C00. Set `enable` = 1 and read address 0, then address 1 on consecutive edges, RD_LAT = 2 → `d_datain` = 00AB at sample edge + 1, then 3C00 on the next edge, `rd_valid` high for 2 cycles, `rd_count` = 2.
- **Write then read.** Write 16'h3CAB to address 2, read address 2 on the next edge → `d_datain` = 3CAB after RD_LAT − 1 edges, `wr_count` = 1.
- **Latency sweep.** Repeat the read test for RD_LAT = 1, 3, 4 → data appears exactly RD_LAT − 1 edges after sampling, with no extra or missing `rd_valid` pulses.
- **Stall and reset flush.** With a read in flight, drop `enable` → the read still completes. Then issue a read and assert `reset` before it completes → `d_datain` = 0, no `rd_valid`, mem[2] still 3CAB after reset is released.
- **Preload gating.** `ld_valid` = 1 while `enable` = 1 → no write occurs (read back the old value). After `enable` falls, `ld_ready` = 1 one edge later and the preload is accepted.
- **Counter saturation.** Force `rd_count` near its limit (or run 65 540 reads) → it stops at FFFF.
